// File: rtl/base_conv_pkg.sv
// Shared definitions for the packed-digit converters (binary <-> packed
// dozenal/decimal).
// Contents:
//   base_e      - encoding of the 2-bit base select
//   state_e     - decoder FSM states
//   NIBBLE_W    - width of one packed digit
//   base_limit  - number of legal digit values for a radix base
package base_conv_pkg;

  typedef enum logic [1:0] {
    BASE_2       = 2'b00,
    BASE_10      = 2'b01,
    BASE_12      = 2'b10,
    BASE_ILLEGAL = 2'b11
  } base_e;

  // S_PASS is a one-cycle settle state for base 2 and the illegal base.
  // It gives those words the same accept-to-result timing as one ACCUM step.
  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_ACCUM,
    S_DONE
  } state_e;

  localparam int unsigned NIBBLE_W = 4;

  // Only the radix bases reach this function in the datapath.
  // Everything that is not base 12 is treated as base 10.
  function automatic logic [3:0] base_limit(input base_e base);
    return (base == BASE_12) ? 4'd12 : 4'd10;
  endfunction

endpackage

// File: rtl/packed_digit_decoder_mac.sv
// base_mac_step: combinational multiply-accumulate step for one digit.
// Ports:
//   acc_i       - running binary accumulator
//   base_i      - radix (BASE_10 or BASE_12)
//   digit_i     - next digit, MSD first
//   acc_o       - acc_i*base + digit_i
//   digit_bad_o - digit_i is not a legal digit for base_i
module base_mac_step
  import base_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  base_e                 base_i,
  input  logic [3:0]            digit_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic                  digit_bad_o
);

  logic [DATA_WIDTH-1:0] accX8;
  logic [DATA_WIDTH-1:0] accLow;

  // Multiply by 10 or 12 using shifts and adds only: x10 = x8 + x2, x12 = x8 + x4.
  // The caller guarantees the result fits in DATA_WIDTH bits.
  always_comb begin
    accX8       = acc_i << 3;
    accLow      = (base_i == BASE_12) ? (acc_i << 2) : (acc_i << 1);
    acc_o       = accX8 + accLow + {{(DATA_WIDTH-4){1'b0}}, digit_i};
    digit_bad_o = (digit_i >= base_limit(base_i));
  end

endmodule

// File: rtl/packed_digit_decoder.sv
// packed_digit_decoder: converts a word of packed base-10/base-12 digits
// (one per nibble, nibble 0 = LSD) into plain binary. Latency is fixed.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid/in_ready       - input handshake
//   in_digits, in_base      - packed digit word and base select
//   out_valid/out_ready     - output handshake, result held until taken
//   out_data                - binary result
//   out_err_digit           - some nibble was >= base (sticky per word)
//   out_err_base            - base select was illegal
//   out_bad_pos             - most-significant offending nibble position
//   busy                    - accumulation in progress
module packed_digit_decoder
  import base_conv_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  localparam int NIBBLES    = DATA_WIDTH / 4,
  localparam int POS_W      = $clog2(NIBBLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_digits,
  input  logic [1:0]            in_base,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err_digit,
  output logic                  out_err_base,
  output logic [POS_W-1:0]      out_bad_pos,
  output logic                  busy
);

  localparam logic [POS_W-1:0] LAST_CNT = POS_W'(NIBBLES - 1);

  state_e                state_q, state_d;
  base_e                 base_q;
  base_e                 inBase;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [POS_W-1:0]      cnt_q;
  logic                  errDigit_q;
  logic                  errBase_q;
  logic [POS_W-1:0]      badPos_q;
  logic [DATA_WIDTH-1:0] macNext;
  logic                  digitBad;
  logic                  accept;

  assign inBase = base_e'(in_base);
  assign accept = (state_q == S_IDLE) && in_valid;

  base_mac_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac (
    .acc_i       (acc_q),
    .base_i      (base_q),
    .digit_i     (shreg_q[DATA_WIDTH-1 -: NIBBLE_W]),
    .acc_o       (macNext),
    .digit_bad_o (digitBad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = (inBase == BASE_10 || inBase == BASE_12) ? S_ACCUM : S_PASS;
        end
      end
      S_PASS:  state_d = S_DONE;
      S_ACCUM: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_ACCUM);
    out_valid = (state_q == S_DONE);
  end

  // The accumulator register doubles as the result register.
  // Base 2 loads it with the word directly and the illegal base loads zero.
  // Only the first bad digit records its position; later ones only keep the
  // sticky flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q     <= BASE_10;
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      errDigit_q <= 1'b0;
      errBase_q  <= 1'b0;
      badPos_q   <= '0;
    end else if (accept) begin
      base_q     <= inBase;
      shreg_q    <= in_digits;
      acc_q      <= (inBase == BASE_2) ? in_digits : '0;
      cnt_q      <= '0;
      errDigit_q <= 1'b0;
      errBase_q  <= (inBase == BASE_ILLEGAL);
      badPos_q   <= '0;
    end else if (state_q == S_ACCUM) begin
      acc_q   <= macNext;
      shreg_q <= shreg_q << NIBBLE_W;
      cnt_q   <= cnt_q + 1'b1;
      if (digitBad) begin
        errDigit_q <= 1'b1;
        if (!errDigit_q) begin
          badPos_q <= LAST_CNT - cnt_q;
        end
      end
    end
  end

  assign out_data      = acc_q;
  assign out_err_digit = errDigit_q;
  assign out_err_base  = errBase_q;
  assign out_bad_pos   = badPos_q;

endmodule

// File: tb/tb_packed_digit_decoder.sv
// Directed and randomized checks of packed_digit_decoder against a
// behavioural decoder written with plain arithmetic.
module tb_packed_digit_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_digits;
  logic [1:0]  in_base;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_err_digit;
  logic        out_err_base;
  logic [3:0]  out_bad_pos;
  logic        busy;

  int checks = 0;
  int errors = 0;

  packed_digit_decoder #(.DATA_WIDTH(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_digits     (in_digits),
    .in_base       (in_base),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_err_digit (out_err_digit),
    .out_err_base  (out_err_base),
    .out_bad_pos   (out_bad_pos),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Decoder written from the digit rules: value = sum of digit_i * base^i.
  task automatic refModel(input logic [63:0] digits, input logic [1:0] base,
                          output logic [63:0] val, output logic errDig,
                          output logic errBase, output logic [3:0] pos,
                          output int lat);
    int radix;
    int d;
    val = 64'd0; errDig = 1'b0; errBase = 1'b0; pos = 4'd0;
    if (base == 2'b00) begin
      val = digits; lat = 1;
    end else if (base == 2'b11) begin
      errBase = 1'b1; lat = 1;
    end else begin
      radix = (base == 2'b01) ? 10 : 12;
      lat = 16;
      for (int i = 15; i >= 0; i--) begin
        d = int'(digits[i*4 +: 4]);
        val = val * 64'(radix) + 64'(d);
        if (d >= radix && !errDig) begin
          errDig = 1'b1;
          pos = 4'(i);
        end
      end
    end
  endtask

  // Present a word for exactly one edge; caller is in IDLE, #1 after an edge.
  task automatic applyStimulus(input logic [63:0] digits, input logic [1:0] base);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_digits = digits;
    in_base   = base;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Wait (bounded) for the result, check it and its latency, then take it.
  task automatic checkOutput(input string tag, input logic [63:0] expData,
                             input logic expErrDig, input logic expErrBase,
                             input logic [3:0] expPos, input int expLat);
    int cyc = 0;
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(expLat));
    check({tag, "_data"}, out_data, expData);
    check({tag, "_err_digit"}, 64'(out_err_digit), 64'(expErrDig));
    check({tag, "_err_base"}, 64'(out_err_base), 64'(expErrBase));
    check({tag, "_bad_pos"}, 64'(out_bad_pos), 64'(expPos));
    @(posedge clk); #1;
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] w, holdData;
    logic [1:0]  b;
    logic [63:0] eVal;
    logic        eDig, eBase;
    logic [3:0]  ePos;
    int          eLat, lim, r, spurious;

    rst_n = 1'b0; in_valid = 1'b0; in_digits = '0; in_base = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_err_digit", 64'(out_err_digit), 64'd0);
    check("reset_err_base", 64'(out_err_base), 64'd0);
    check("reset_bad_pos", 64'(out_bad_pos), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    applyStimulus(64'h0000_0000_0000_0B0A, 2'b10);
    checkOutput("b12_0B0A", 64'd1594, 1'b0, 1'b0, 4'd0, 16);
    applyStimulus(64'h0000_0000_0012_3456, 2'b01);
    checkOutput("b10_123456", 64'd123456, 1'b0, 1'b0, 4'd0, 16);
    applyStimulus(64'h9999_9999_9999_9999, 2'b01);
    checkOutput("b10_all9", 64'd9999999999999999, 1'b0, 1'b0, 4'd0, 16);
    applyStimulus(64'h0000_0000_0000_A000, 2'b01);
    checkOutput("b10_badA", 64'd10000, 1'b1, 1'b0, 4'd3, 16);
    applyStimulus(64'h0000_0000_00C0_0C00, 2'b10);
    checkOutput("b12_badC", 64'd2987712, 1'b1, 1'b0, 4'd5, 16);
    applyStimulus(64'hDEAD_BEEF_0123_4567, 2'b00);
    checkOutput("b2_pass", 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 4'd0, 1);
    applyStimulus(64'h0000_0000_0000_1234, 2'b11);
    checkOutput("illegal_base", 64'd0, 1'b0, 1'b1, 4'd0, 1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(64'h0000_0000_0098_7654, 2'b01);
    r = 0;
    while (!out_valid && r < 64) begin
      @(posedge clk); #1;
      r++;
    end
    check("bp_latency", 64'(r), 64'd16);
    holdData = out_data;
    check("bp_data", holdData, 64'd987654);
    for (int i = 0; i < 5; i++) begin
      in_digits = 64'h0000_0000_0000_0BBB;
      in_base   = 2'b10;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_data", out_data, holdData);
      check("bp_hold_err_digit", 64'(out_err_digit), 64'd0);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_busy", 64'(busy), 64'd0);
    applyStimulus(64'h0000_0000_0000_0BBB, 2'b10);
    checkOutput("bp_second", 64'd1727, 1'b0, 1'b0, 4'd0, 16);

    $display("[TB] reset mid-decode");
    applyStimulus(64'h1234_5678_9012_3456, 2'b01);
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_out_valid", 64'(out_valid), 64'd0);
    check("mid_reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    check("mid_reset_no_result", 64'(spurious), 64'd0);
    applyStimulus(64'hBBBB_BBBB_BBBB_BBBB, 2'b10);
    checkOutput("after_reset_allB", 64'd184884258895036415, 1'b0, 1'b0, 4'd0, 16);

    $display("[TB] randomized words");
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      b = 2'b00;
      else if (r == 1) b = 2'b11;
      else if (r < 6)  b = 2'b01;
      else             b = 2'b10;
      lim = (b == 2'b10) ? 12 : 10;
      if (b == 2'b00 || b == 2'b11) begin
        w = {$urandom, $urandom};
      end else begin
        w = '0;
        for (int i = 0; i < 16; i++) begin
          if ($urandom_range(0, 19) == 0)
            w[i*4 +: 4] = 4'($urandom_range(0, 15));
          else
            w[i*4 +: 4] = 4'($urandom_range(0, lim - 1));
        end
      end
      refModel(w, b, eVal, eDig, eBase, ePos, eLat);
      applyStimulus(w, b);
      checkOutput($sformatf("rand%0d", n), eVal, eDig, eBase, ePos, eLat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
